// File: rtl/cache_pkg.sv
// +-----------------------------------------------------------------------+
// | cache_pkg: shared types, widths and parity helper for the data bank.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package cache_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    REFILL = 2'd2
  } bank_state_t;

  // Even parity: the stored bit makes each 9-bit lane have an even count of ones.
  function automatic logic [BYTES_PER_WORD-1:0] byte_parity(input logic [WORD_W-1:0] word);
    logic [BYTES_PER_WORD-1:0] par;
    par = '0;
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      par[b] = ^word[b*8 +: 8];
    end
    return par;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_bank_ram.sv
// +-----------------------------------------------------------------------+
// | cache_bank_ram: single-port read-first line RAM with per-lane writes. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module cache_bank_ram #(
  parameter int ADDR_W = 7,
  parameter int LANES  = 32,
  parameter int LANE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      re,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [LANES-1:0]          we,
  input  logic [LANES*LANE_W-1:0]   wdata,
  output logic [LANES*LANE_W-1:0]   rdata
);

  logic [LANES*LANE_W-1:0] r_mem [0:(2**ADDR_W)-1];
  logic [LANES*LANE_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (we[l]) begin
        r_mem[addr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
      end
    end
  end

  // Output register holds its value until the next read; reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/cache_data_bank.sv
// +-----------------------------------------------------------------------+
// | cache_data_bank: L1 D-cache data array with CPU read/store, critical- |
// | word-first refill and self-clear. Optional CACHE_BANK_PARITY_EN adds  |
// | per-byte even parity. Revision: 1.0                                   |
// +-----------------------------------------------------------------------+
`default_nettype none

module cache_data_bank
  import cache_pkg::*;
#(
  parameter  int SET_W      = 7,
  parameter  int LINE_WORDS = 8,
  localparam int OFF_W      = $clog2(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_valid,
  output logic                         rd_ready,
  input  logic [SET_W-1:0]             rd_index,
  input  logic [OFF_W-1:0]             rd_offset,
  output logic                         rd_data_valid,
  output logic [31:0]                  rd_data,
  output logic [32*LINE_WORDS-1:0]     rd_line,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [SET_W-1:0]             st_index,
  input  logic [OFF_W-1:0]             st_offset,
  input  logic [3:0]                   st_wstrb,
  input  logic [31:0]                  st_data,
  input  logic                         rf_start,
  input  logic [SET_W-1:0]             rf_index,
  input  logic [OFF_W-1:0]             rf_offset,
  input  logic                         rf_beat_valid,
  output logic                         rf_beat_ready,
  input  logic [31:0]                  rf_beat_data,
  output logic                         rf_crit_valid,
  output logic                         rf_done,
  output logic                         busy,
  output logic                         rd_parity_err
);

`ifdef CACHE_BANK_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam int LANES = LINE_WORDS * BYTES_PER_WORD;

  bank_state_t r_state, w_next;

  logic [SET_W-1:0]  r_sweep;
  logic [OFF_W-1:0]  r_beat;
  logic [SET_W-1:0]  r_rf_index;
  logic [OFF_W-1:0]  r_rf_offset;
  logic [OFF_W-1:0]  r_rd_offset;
  logic              r_rd_data_valid;
  logic              r_rf_done;

  logic              w_init;
  logic              w_idle;
  logic              w_refill;
  logic              w_st_fire;
  logic              w_rd_fire;
  logic              w_beat_fire;
  logic              w_last_beat;
  logic [OFF_W-1:0]  w_wr_slot;
  logic [3:0]        w_word_strb;
  logic [WORD_W-1:0] w_wr_word;
  logic [SET_W-1:0]  w_addr;
  logic [LANES-1:0]  w_we;
  logic [LANES*LANE_W-1:0] w_wdata;
  logic [LANES*LANE_W-1:0] w_rdata;

  assign w_init      = (r_state == INIT);
  assign w_idle      = (r_state == IDLE);
  assign w_refill    = (r_state == REFILL);
  assign w_st_fire   = w_idle && st_valid;
  assign w_beat_fire = w_refill && rf_beat_valid;
  assign w_last_beat = (r_beat == OFF_W'(LINE_WORDS - 1));

  assign st_ready      = w_idle;
  assign rd_ready      = (w_idle && !st_valid) || (w_refill && !rf_beat_valid);
  assign w_rd_fire     = rd_valid && rd_ready;
  assign rf_beat_ready = w_refill;
  assign rf_crit_valid = w_beat_fire && (r_beat == '0);
  assign rf_done       = r_rf_done;
  assign busy          = w_init || w_refill;
  assign rd_data_valid = r_rd_data_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      INIT:    if (r_sweep == '1) w_next = IDLE;
      IDLE:    if (rf_start) w_next = REFILL;
      REFILL:  if (w_beat_fire && w_last_beat) w_next = IDLE;
      default: w_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sweep         <= '0;
      r_beat          <= '0;
      r_rf_index      <= '0;
      r_rf_offset     <= '0;
      r_rd_offset     <= '0;
      r_rd_data_valid <= 1'b0;
      r_rf_done       <= 1'b0;
    end else begin
      r_rd_data_valid <= w_rd_fire;
      r_rf_done       <= w_beat_fire && w_last_beat;
      if (w_rd_fire) begin
        r_rd_offset <= rd_offset;
      end
      if (w_init) begin
        r_sweep <= r_sweep + 1'b1;
      end
      if (w_idle && rf_start) begin
        r_rf_index  <= rf_index;
        r_rf_offset <= rf_offset;
        r_beat      <= '0;
      end else if (w_beat_fire) begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  // Refill slot wraps naturally in OFF_W bits, giving critical-word-first order.
  assign w_wr_slot   = w_refill ? (r_rf_offset + r_beat) : st_offset;
  assign w_word_strb = w_beat_fire ? 4'hF : st_wstrb;
  assign w_wr_word   = w_init ? '0 : (w_refill ? rf_beat_data : st_data);

  always_comb begin
    w_addr = rd_index;
    if (w_init) begin
      w_addr = r_sweep;
    end else if (w_beat_fire) begin
      w_addr = r_rf_index;
    end else if (w_st_fire) begin
      w_addr = st_index;
    end
  end

  for (genvar gw = 0; gw < LINE_WORDS; gw++) begin : g_word_we
    for (genvar gb = 0; gb < BYTES_PER_WORD; gb++) begin : g_byte_we
      assign w_we[gw*BYTES_PER_WORD + gb] = w_init ||
          ((w_beat_fire || w_st_fire) && (w_wr_slot == OFF_W'(gw)) && w_word_strb[gb]);
    end
  end

`ifdef CACHE_BANK_PARITY_EN
  logic [BYTES_PER_WORD-1:0] w_wr_par;
  logic [LANES-1:0]          w_stored_par;

  assign w_wr_par = byte_parity(w_wr_word);

  for (genvar gl = 0; gl < LANES; gl++) begin : g_lane_par
    assign w_wdata[gl*LANE_W +: LANE_W] =
        {w_wr_par[gl % BYTES_PER_WORD], w_wr_word[(gl % BYTES_PER_WORD)*8 +: 8]};
    assign rd_line[gl*8 +: 8] = w_rdata[gl*LANE_W +: 8];
    assign w_stored_par[gl]   = w_rdata[gl*LANE_W + 8];
  end

  assign rd_parity_err =
      |(w_stored_par[r_rd_offset*BYTES_PER_WORD +: BYTES_PER_WORD] ^ byte_parity(rd_data));
`else
  assign w_wdata       = {LINE_WORDS{w_wr_word}};
  assign rd_line       = w_rdata;
  assign rd_parity_err = 1'b0;
`endif

  assign rd_data = rd_line[r_rd_offset*WORD_W +: WORD_W];

  cache_bank_ram #(
    .ADDR_W (SET_W),
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .re    (w_rd_fire),
    .addr  (w_addr),
    .we    (w_we),
    .wdata (w_wdata),
    .rdata (w_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_cache_data_bank.sv
// +-----------------------------------------------------------------------+
// | tb_cache_data_bank: self-checking bench with table vectors, directed  |
// | corner sequences and randomized traffic against a line-array model.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_cache_data_bank;

  localparam int SET_W      = 7;
  localparam int LINE_WORDS = 8;
  localparam int OFF_W      = 3;
  localparam int SETS       = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst = 1'b1;
  logic                     rd_valid = 1'b0, rd_ready;
  logic [SET_W-1:0]         rd_index = '0;
  logic [OFF_W-1:0]         rd_offset = '0;
  logic                     rd_data_valid;
  logic [31:0]              rd_data;
  logic [32*LINE_WORDS-1:0] rd_line;
  logic                     st_valid = 1'b0, st_ready;
  logic [SET_W-1:0]         st_index = '0;
  logic [OFF_W-1:0]         st_offset = '0;
  logic [3:0]               st_wstrb = '0;
  logic [31:0]              st_data = '0;
  logic                     rf_start = 1'b0;
  logic [SET_W-1:0]         rf_index = '0;
  logic [OFF_W-1:0]         rf_offset = '0;
  logic                     rf_beat_valid = 1'b0, rf_beat_ready;
  logic [31:0]              rf_beat_data = '0;
  logic                     rf_crit_valid, rf_done, busy, rd_parity_err;

  cache_data_bank #(.SET_W(SET_W), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_index(rd_index), .rd_offset(rd_offset),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_line(rd_line),
    .st_valid(st_valid), .st_ready(st_ready), .st_index(st_index), .st_offset(st_offset),
    .st_wstrb(st_wstrb), .st_data(st_data),
    .rf_start(rf_start), .rf_index(rf_index), .rf_offset(rf_offset),
    .rf_beat_valid(rf_beat_valid), .rf_beat_ready(rf_beat_ready), .rf_beat_data(rf_beat_data),
    .rf_crit_valid(rf_crit_valid), .rf_done(rf_done), .busy(busy), .rd_parity_err(rd_parity_err)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model [SETS][LINE_WORDS];

  typedef struct {
    bit          is_store;
    int          idx;
    int          off;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [10];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%064h required=%064h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [255:0] model_line(input int idx);
    logic [255:0] l;
    for (int w = 0; w < LINE_WORDS; w++) l[w*32 +: 32] = model[idx][w];
    return l;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < LINE_WORDS; w++) model[s][w] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_store(input int idx, input int off, input logic [3:0] strb, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (strb[b]) model[idx][off][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic do_store(input int idx, input int off, input logic [3:0] strb, input logic [31:0] d);
    st_valid = 1'b1; st_index = SET_W'(idx); st_offset = OFF_W'(off);
    st_wstrb = strb; st_data = d;
    #1;
    check1("st_ready", st_ready, 1'b1);
    tick();
    st_valid = 1'b0;
    model_store(idx, off, strb, d);
  endtask

  task automatic do_read(input int idx, input int off, output logic [31:0] got);
    logic [31:0]  exp_w;
    logic [255:0] exp_l;
    rd_valid = 1'b1; rd_index = SET_W'(idx); rd_offset = OFF_W'(off);
    #1;
    check1("rd_ready", rd_ready, 1'b1);
    exp_w = model[idx][off];
    exp_l = model_line(idx);
    tick();
    rd_valid = 1'b0;
    check1("rd_data_valid", rd_data_valid, 1'b1);
    check32("rd_data", rd_data, exp_w);
    check_line("rd_line", rd_line, exp_l);
    check1("rd_parity_err", rd_parity_err, 1'b0);
    got = rd_data;
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      if (rf_done) check1("rf_done_in_init", rf_done, 1'b0);
      check1("rd_ready_in_init", rd_ready, 1'b0);
      n++;
      tick();
    end
    check_int(name, n, SETS);
  endtask

  // Random refill: beats may stall, and stalls may carry a read of any tracked set.
  task automatic do_refill_rand(input int idx, input int off);
    logic [31:0] d, got;
    int gaps;
    rf_start = 1'b1; rf_index = SET_W'(idx); rf_offset = OFF_W'(off);
    tick();
    rf_start = 1'b0;
    for (int k = 0; k < LINE_WORDS; k++) begin
      gaps = $urandom_range(2);
      for (int g = 0; g < gaps; g++) begin
        rf_beat_valid = 1'b0;
        do_read($urandom_range(7), $urandom_range(LINE_WORDS-1), got);
      end
      d = $urandom;
      rf_beat_valid = 1'b1; rf_beat_data = d;
      #1;
      check1("rnd_crit_valid", rf_crit_valid, k == 0);
      check1("rnd_rf_done_early", rf_done, 1'b0);
      tick();
      model[idx][(off + k) % LINE_WORDS] = d;
    end
    rf_beat_valid = 1'b0;
    check1("rnd_rf_done", rf_done, 1'b1);
    tick();
    check1("rnd_rf_done_pulse", rf_done, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got;
    int          k, cyc;

    clear_model();
    vecs[0] = '{1'b1,   5, 3, 4'b0101, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0,   5, 3, 4'b0000, 32'h0,        32'h00AD00EF};
    vecs[2] = '{1'b1,   5, 3, 4'b1010, 32'h12345678, 32'h0};
    vecs[3] = '{1'b0,   5, 3, 4'b0000, 32'h0,        32'h12AD56EF};
    vecs[4] = '{1'b0,   5, 2, 4'b0000, 32'h0,        32'h00000000};
    vecs[5] = '{1'b1, 127, 7, 4'b1111, 32'hCAFEF00D, 32'h0};
    vecs[6] = '{1'b0, 127, 7, 4'b0000, 32'h0,        32'hCAFEF00D};
    vecs[7] = '{1'b1,   5, 0, 4'b1000, 32'hAABBCCDD, 32'h0};
    vecs[8] = '{1'b0,   5, 0, 4'b0000, 32'h0,        32'hAA000000};
    vecs[9] = '{1'b0,   0, 0, 4'b0000, 32'h0,        32'h00000000};

    // Reset values
    tick(); tick(); tick();
    check1("rst_busy", busy, 1'b1);
    check1("rst_rd_ready", rd_ready, 1'b0);
    check1("rst_st_ready", st_ready, 1'b0);
    check1("rst_rf_beat_ready", rf_beat_ready, 1'b0);
    check1("rst_rd_data_valid", rd_data_valid, 1'b0);
    check32("rst_rd_data", rd_data, 32'h0);
    check_line("rst_rd_line", rd_line, '0);
    check1("rst_rf_crit_valid", rf_crit_valid, 1'b0);
    check1("rst_rf_done", rf_done, 1'b0);
    check1("rst_rd_parity_err", rd_parity_err, 1'b0);
    rst = 1'b0;
    wait_init("init_cycles");

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_store) begin
        do_store(vecs[i].idx, vecs[i].off, vecs[i].strb, vecs[i].data);
      end else begin
        do_read(vecs[i].idx, vecs[i].off, got);
        check32("vec_rd_data", got, vecs[i].exp);
      end
    end

    // Store and read contend in IDLE: store wins, read retried next cycle
    st_valid = 1'b1; st_index = 7'd9; st_offset = 3'd1; st_wstrb = 4'hF; st_data = 32'h55667788;
    rd_valid = 1'b1; rd_index = 7'd9; rd_offset = 3'd1;
    #1;
    check1("contend_rd_ready", rd_ready, 1'b0);
    check1("contend_st_ready", st_ready, 1'b1);
    tick();
    st_valid = 1'b0;
    model_store(9, 1, 4'hF, 32'h55667788);
    check1("contend_no_rd_valid", rd_data_valid, 1'b0);
    do_read(9, 1, got);
    check32("contend_retry", got, 32'h55667788);

    // Wrapped refill of set 20 from offset 6 with a store served in the start cycle
    rf_start = 1'b1; rf_index = 7'd20; rf_offset = 3'd6;
    st_valid = 1'b1; st_index = 7'd5; st_offset = 3'd1; st_wstrb = 4'hF; st_data = 32'h0BADF00D;
    #1;
    check1("rf_start_st_ready", st_ready, 1'b1);
    tick();
    rf_start = 1'b0; st_valid = 1'b0;
    model_store(5, 1, 4'hF, 32'h0BADF00D);
    check1("refill_busy", busy, 1'b1);
    check1("refill_st_ready", st_ready, 1'b0);
    cyc = 1;
    for (k = 0; k < LINE_WORDS; k++) begin
      if (k == 3) begin
        rf_beat_valid = 1'b0;
        do_read(5, 1, got);
        check32("gap_read", got, 32'h0BADF00D);
        cyc++;
      end
      rf_beat_valid = 1'b1; rf_beat_data = 32'(16 + k);
      rd_valid = (k == 4); rd_index = 7'd5; rd_offset = 3'd3;
      #1;
      check1("beat_ready", rf_beat_ready, 1'b1);
      check1("crit_valid", rf_crit_valid, k == 0);
      check1("rf_done_early", rf_done, 1'b0);
      if (k == 4) check1("beat_blocks_read", rd_ready, 1'b0);
      tick();
      if (k == 4) check1("blocked_read_no_valid", rd_data_valid, 1'b0);
      rd_valid = 1'b0;
      model[20][(6 + k) % LINE_WORDS] = 32'(16 + k);
      cyc++;
    end
    rf_beat_valid = 1'b0;
    check1("rf_done_after_last", rf_done, 1'b1);
    check1("busy_after_refill", busy, 1'b0);
    check_int("refill_cycles", cyc + 1, LINE_WORDS + 3);
    tick();
    check1("rf_done_one_cycle", rf_done, 1'b0);
    for (int w = 0; w < LINE_WORDS; w++) begin
      do_read(20, w, got);
      check32("wrap_word", got, 32'(16 + ((w + LINE_WORDS - 6) % LINE_WORDS)));
    end

    // Randomized traffic over a few sets to force collisions
    for (int it = 0; it < 150; it++) begin
      int op;
      op = $urandom_range(9);
      if (op < 4) begin
        do_store($urandom_range(7), $urandom_range(LINE_WORDS-1), 4'($urandom_range(15)), $urandom);
      end else if (op < 8) begin
        do_read($urandom_range(7), $urandom_range(LINE_WORDS-1), got);
      end else if (op == 8) begin
        int si, so;
        logic [31:0] sd;
        si = $urandom_range(7); so = $urandom_range(LINE_WORDS-1); sd = $urandom;
        st_valid = 1'b1; st_index = SET_W'(si); st_offset = OFF_W'(so); st_wstrb = 4'hF; st_data = sd;
        rd_valid = 1'b1; rd_index = SET_W'(si); rd_offset = OFF_W'(so);
        #1;
        check1("rnd_contend_rd_ready", rd_ready, 1'b0);
        tick();
        st_valid = 1'b0;
        model_store(si, so, 4'hF, sd);
        do_read(si, so, got);
        check32("rnd_contend_data", got, sd);
      end else begin
        do_refill_rand($urandom_range(7), $urandom_range(LINE_WORDS-1));
      end
    end

    // Reset after three beats: no done pulse, sweep restarts, set cleared
    rf_start = 1'b1; rf_index = 7'd30; rf_offset = 3'd2;
    tick();
    rf_start = 1'b0;
    for (k = 0; k < 3; k++) begin
      rf_beat_valid = 1'b1; rf_beat_data = 32'hA0 + 32'(k);
      tick();
      check1("abort_rf_done", rf_done, 1'b0);
    end
    rf_beat_valid = 1'b0;
    rst = 1'b1;
    tick();
    check1("abort_busy", busy, 1'b1);
    check1("abort_beat_ready", rf_beat_ready, 1'b0);
    check1("abort_rf_done_rst", rf_done, 1'b0);
    rst = 1'b0;
    clear_model();
    wait_init("reinit_cycles");
    for (int w = 0; w < LINE_WORDS; w++) begin
      do_read(30, w, got);
      check32("abort_cleared", got, 32'h0);
    end
    do_read(5, 3, got);
    check32("reinit_set5", got, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
